// File: rtl/mux_scan_nto1.sv
// Registered N-to-1 channel mux with manual select and auto-scan.
// Manual mode follows sel with one cycle of latency. Auto mode steps
// through the channels, staying DWELL cycles on each, with a wrap pulse
// on the step from the last channel back to channel 0.

// One channel lane: passes its data only when its select line is high,
// so the mux is an OR over all lanes.
module mux_scan_lane #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    output logic [WIDTH-1:0] dout
);
    assign dout = din & {WIDTH{en}};
endmodule

module mux_scan_nto1 #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      hold,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    output logic                      wrap
);
    // Dwell counter needs at least one bit even when DWELL is 1.
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [SEL_W:0]   CH_LIM  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);
    localparam logic [DW-1:0]    DW_MAX  = DW'(DWELL - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] ch;
        logic             vld;
        logic             wrap;
    } rsp_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic             vld_d;
    logic             wrap_d;
    logic             sel_ok;
    rsp_t             rsp_q, rsp_d;

    logic [CHANNELS-1:0][WIDTH-1:0] in_arr;
    logic [CHANNELS-1:0][WIDTH-1:0] lane_out;
    logic [CHANNELS-1:0]            lane_en;
    logic [WIDTH-1:0]               mux_data;

    assign in_arr = in;
    assign sel_ok = ({1'b0, sel} < CH_LIM);

    // Mode is sampled every edge; a mode change wins over hold and dwell expiry.
    always_comb begin
        state_d = mode ? AUTO : MANUAL;
        chan_d  = chan_q;
        dwell_d = dwell_q;
        vld_d   = 1'b1;
        wrap_d  = 1'b0;
        if (!mode) begin
            // Manual, including the edge that leaves auto: any pending wrap is dropped.
            chan_d  = sel;
            dwell_d = '0;
            vld_d   = sel_ok;
        end else if (state_q == MANUAL) begin
            // Entering auto: start from sel when it names a real channel.
            chan_d  = sel_ok ? sel : '0;
            dwell_d = '0;
        end else if (!hold) begin
            if (dwell_q == DW_MAX) begin
                dwell_d = '0;
                if (chan_q == CH_LAST) begin
                    chan_d = '0;
                    wrap_d = 1'b1;
                end else begin
                    chan_d = chan_q + SEL_W'(1);
                end
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    // Output reflects the channel being entered on this edge, so every
    // channel is shown for exactly DWELL cycles per pass.
    genvar k;
    generate
        for (k = 0; k < CHANNELS; k++) begin : g_lane
            assign lane_en[k] = vld_d && (chan_d == SEL_W'(k));
            mux_scan_lane #(.WIDTH(WIDTH)) u_lane (
                .din  (in_arr[k]),
                .en   (lane_en[k]),
                .dout (lane_out[k])
            );
        end
    endgenerate

    // OR-combine the gated lanes; at most one is enabled.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mux_data = mux_data | lane_out[i];
        end
    end

    // Assemble the next registered response.
    always_comb begin
        rsp_d      = '0;
        rsp_d.data = mux_data;
        rsp_d.ch   = chan_d;
        rsp_d.vld  = vld_d;
        rsp_d.wrap = wrap_d;
    end

    // State, scan position and output registers; reset clears all immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MANUAL;
            chan_q  <= '0;
            dwell_q <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            dwell_q <= dwell_d;
            rsp_q   <= rsp_d;
        end
    end

    assign out       = rsp_q.data;
    assign out_ch    = rsp_q.ch;
    assign out_valid = rsp_q.vld;
    assign wrap      = rsp_q.wrap;
endmodule

// File: tb/tb_mux_scan_nto1.sv
// Directed and randomized checks of mux_scan_nto1 against a scan-position model.
module tb_mux_scan_nto1;
    localparam int W  = 4;
    localparam int C  = 4;
    localparam int D  = 3;
    localparam int SW = $clog2(C);

    logic            clk;
    logic            reset_n;
    logic [C*W-1:0]  in_v;
    logic            mode;
    logic [SW-1:0]   sel;
    logic            hold;
    logic [W-1:0]    out;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            wrap;

    int total = 0;
    int bad   = 0;

    // Model: in auto, the channel is a function of start channel and the
    // number of non-held cycles since entry.
    bit     m_auto;
    int     m_start;
    int     m_pos;
    int     e_out, e_ch, e_valid, e_wrap;

    mux_scan_nto1 #(.WIDTH(W), .CHANNELS(C), .DWELL(D)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in        (in_v),
        .mode      (mode),
        .sel       (sel),
        .hold      (hold),
        .out       (out),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int chdat(int k);
        return int'(in_v[k*W +: W]);
    endfunction

    task automatic model_reset();
        m_auto  = 1'b0;
        m_start = 0;
        m_pos   = 0;
        e_out   = 0;
        e_ch    = 0;
        e_valid = 0;
        e_wrap  = 0;
    endtask

    task automatic model_clk();
        if (!mode) begin
            m_auto  = 1'b0;
            e_ch    = int'(sel);
            e_valid = (int'(sel) < C) ? 1 : 0;
            e_out   = e_valid ? chdat(e_ch) : 0;
            e_wrap  = 0;
        end else begin
            if (!m_auto) begin
                m_auto  = 1'b1;
                m_start = (int'(sel) < C) ? int'(sel) : 0;
                m_pos   = 0;
                e_wrap  = 0;
            end else if (!hold) begin
                m_pos++;
                e_wrap = ((m_pos % D) == 0 && ((m_start + m_pos / D) % C) == 0) ? 1 : 0;
            end else begin
                e_wrap = 0;
            end
            e_ch    = (m_start + m_pos / D) % C;
            e_valid = 1;
            e_out   = chdat(e_ch);
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"},   int'(out),       e_out);
        check({tag, ".ch"},    int'(out_ch),    e_ch);
        check({tag, ".valid"}, int'(out_valid), e_valid);
        check({tag, ".wrap"},  int'(wrap),      e_wrap);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_clk();
        #1;
        check_all(tag);
    endtask

    int exp_seq[13] = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1, 1, 1, 2};
    logic [3:0] pat;
    int wraps;

    initial begin
        reset_n = 1'b0;
        mode    = 1'b0;
        hold    = 1'b0;
        sel     = '0;
        in_v    = C*W'($urandom);
        model_reset();

        // Reset: outputs stay 0 across clock edges while reset is low.
        step("rst0");
        in_v = C*W'($urandom); sel = SW'($urandom);
        step("rst1");
        reset_n = 1'b1;

        // Manual sweep over channel data DCBA.
        in_v = {4'hD, 4'hC, 4'hB, 4'hA};
        for (int s = 0; s < C; s++) begin
            sel = SW'(s);
            step("man_sweep");
            check("man_sweep.const", int'(out), 4'hA + s);
        end

        // Exhaustive bit-0 patterns for each select.
        for (int s = 0; s < C; s++) begin
            for (int p = 0; p < 16; p++) begin
                pat = 4'(p);
                sel = SW'(s);
                for (int k = 0; k < C; k++) in_v[k*W +: W] = {3'b0, pat[k]};
                step("man_exh");
                check("man_exh.bit", int'(out[0]), int'(pat[s]));
            end
        end

        // Auto scan from channel 2 with live data.
        mode  = 1'b1;
        sel   = 2'd2;
        wraps = 0;
        for (int i = 0; i < 13; i++) begin
            in_v = C*W'($urandom);
            step("auto");
            check("auto.seq", int'(out_ch), exp_seq[i]);
            check("auto.wrapat", int'(wrap), (i == 6) ? 1 : 0);
            wraps += int'(wrap);
        end
        check("auto.wraps", wraps, 1);

        // Hold on channel 1 with dwell count 1.
        mode = 1'b0; sel = 2'd0;
        step("hold_pre");
        mode = 1'b1; sel = 2'd1;
        step("hold_enter");
        step("hold_d1");
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_v = C*W'($urandom);
            step("hold_on");
            check("hold_on.ch", int'(out_ch), 1);
        end
        hold = 1'b0;
        step("hold_rel");
        check("hold_rel.ch", int'(out_ch), 1);
        step("hold_adv");
        check("hold_adv.ch", int'(out_ch), 2);

        // Leave auto on ch3 at the last dwell cycle: wrap is suppressed.
        mode = 1'b0; sel = 2'd3;
        step("sw_pre");
        mode = 1'b1;
        step("sw_enter");
        step("sw_d1");
        step("sw_d2");
        mode = 1'b0; sel = 2'd1;
        step("sw_exit");
        check("sw_exit.ch", int'(out_ch), 1);
        check("sw_exit.wrap", int'(wrap), 0);
        mode = 1'b1;
        for (int i = 0; i < D + 1; i++) begin
            step("sw_reenter");
            check("sw_reenter.ch", int'(out_ch), (i < D) ? 1 : 2);
        end

        // Asynchronous reset in the middle of a cycle during auto.
        step("mid_a");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        step("async_rst_edge");
        reset_n = 1'b1;
        mode = 1'b0; sel = 2'd2;
        in_v = C*W'($urandom);
        step("post_rst");
        check("post_rst.valid", int'(out_valid), 1);

        // Randomized mode/sel/hold/data traffic.
        for (int i = 0; i < 600; i++) begin
            in_v = C*W'($urandom);
            sel  = SW'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
